// File: rtl/ex_muldiv_sequencer_if.sv
// EX-stage bundle between the pipeline, the shared ALU and the MULTU/DIVU sequencer.
// The master modport drives requests and the ALU result; the slave modport is the sequencer.
interface ex_muldiv_sequencer_if;
   logic        Start_EX;
   logic [1:0]  Op_EX;
   logic [31:0] Read_Data_1_EX;
   logic [31:0] Read_Data_2_EX;
   logic [3:0]  Pipe_ALU_Control_EX;
   logic [31:0] Pipe_ALU_Data_1_EX;
   logic [31:0] Pipe_ALU_Data_2_EX;
   logic [31:0] ALU_Result_EX;
   logic [3:0]  ALU_Control_Out_EX;
   logic [31:0] ALU_Data_1_Out_EX;
   logic [31:0] ALU_Data_2_Out_EX;
   logic        Stall_EX;
   logic        Busy_EX;
   logic        Done_EX;
   logic [31:0] HI_EX;
   logic [31:0] LO_EX;
   logic        Div_Zero_EX;

   modport master (
      output Start_EX, Op_EX, Read_Data_1_EX, Read_Data_2_EX,
             Pipe_ALU_Control_EX, Pipe_ALU_Data_1_EX, Pipe_ALU_Data_2_EX, ALU_Result_EX,
      input  ALU_Control_Out_EX, ALU_Data_1_Out_EX, ALU_Data_2_Out_EX,
             Stall_EX, Busy_EX, Done_EX, HI_EX, LO_EX, Div_Zero_EX
   );

   modport slave (
      input  Start_EX, Op_EX, Read_Data_1_EX, Read_Data_2_EX,
             Pipe_ALU_Control_EX, Pipe_ALU_Data_1_EX, Pipe_ALU_Data_2_EX, ALU_Result_EX,
      output ALU_Control_Out_EX, ALU_Data_1_Out_EX, ALU_Data_2_Out_EX,
             Stall_EX, Busy_EX, Done_EX, HI_EX, LO_EX, Div_Zero_EX
   );
endinterface

// File: rtl/ex_muldiv_sequencer.sv
// MULTU/DIVU sequencer borrowing the EX ALU: start at cycle 0, 32 iterations, Done in cycle 33.
// Stalls the pipeline from the accepting cycle through the last iteration; starts while busy are dropped.
module ex_muldiv_sequencer #(
   parameter logic [3:0] ALU_ADD = 4'b0010,
   parameter logic [3:0] ALU_SUB = 4'b0110,
   parameter int         ITER    = 32
) (
   input logic                  Clk,
   input logic                  Reset,
   ex_muldiv_sequencer_if.slave bus
);
   typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

   state_t      state;
   state_t      state_nxt;
   logic [31:0] hi;
   logic [31:0] lo;
   logic [31:0] m;
   logic [5:0]  count;
   logic        div_zero;
   logic        start_ok;
   logic        last_iter;
   logic [31:0] rem_shift;
   logic        carry;
   logic        take_sub;

   assign start_ok  = (state == IDLE) & bus.Start_EX & ~bus.Op_EX[1];
   assign last_iter = (count == 6'(ITER - 1));
   assign rem_shift = {hi[30:0], lo[31]};
   // The ALU returns only 32 bits, so the add carry is recovered by wraparound detection.
   assign carry     = (bus.ALU_Result_EX < hi);
   assign take_sub  = hi[31] | (rem_shift >= m);

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:     if (start_ok) state_nxt = bus.Op_EX[0] ? DIV : MUL;
         MUL, DIV: if (last_iter) state_nxt = DONE;
         default:  state_nxt = IDLE;
      endcase
   end

   always_comb begin
      bus.ALU_Control_Out_EX = bus.Pipe_ALU_Control_EX;
      bus.ALU_Data_1_Out_EX  = bus.Pipe_ALU_Data_1_EX;
      bus.ALU_Data_2_Out_EX  = bus.Pipe_ALU_Data_2_EX;
      bus.Stall_EX           = start_ok;
      bus.Busy_EX            = 1'b0;
      bus.Done_EX            = 1'b0;
      case (state)
         MUL: begin
            bus.ALU_Control_Out_EX = ALU_ADD;
            bus.ALU_Data_1_Out_EX  = hi;
            bus.ALU_Data_2_Out_EX  = m;
            bus.Stall_EX           = 1'b1;
            bus.Busy_EX            = 1'b1;
         end
         DIV: begin
            bus.ALU_Control_Out_EX = ALU_SUB;
            bus.ALU_Data_1_Out_EX  = rem_shift;
            bus.ALU_Data_2_Out_EX  = m;
            bus.Stall_EX           = 1'b1;
            bus.Busy_EX            = 1'b1;
         end
         DONE:    bus.Done_EX = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge Clk) begin
      if (Reset) begin
         hi       <= '0;
         lo       <= '0;
         m        <= '0;
         count    <= '0;
         div_zero <= 1'b0;
      end else begin
         case (state)
            IDLE: if (start_ok) begin
               hi       <= '0;
               lo       <= bus.Op_EX[0] ? bus.Read_Data_1_EX : bus.Read_Data_2_EX;
               m        <= bus.Op_EX[0] ? bus.Read_Data_2_EX : bus.Read_Data_1_EX;
               count    <= '0;
               div_zero <= 1'b0;
            end
            MUL: begin
               count <= count + 6'd1;
               if (lo[0]) {hi, lo} <= {carry, bus.ALU_Result_EX, lo[31:1]};
               else       {hi, lo} <= {1'b0, hi, lo[31:1]};
            end
            DIV: begin
               count <= count + 6'd1;
               if (take_sub) begin
                  hi <= bus.ALU_Result_EX;
                  lo <= {lo[30:0], 1'b1};
               end else begin
                  hi <= rem_shift;
                  lo <= {lo[30:0], 1'b0};
               end
               // Zero divisor needs no special datapath; the flag just rides along with Done.
               if (last_iter) div_zero <= (m == 32'd0);
            end
            default: ;
         endcase
      end
   end

   assign bus.HI_EX       = hi;
   assign bus.LO_EX       = lo;
   assign bus.Div_Zero_EX = div_zero;
endmodule
